fir_tdm_sequencer: RTL and testbench

- Time-multiplexed FIR controller for the I/Q receive chain. Replaces the fully parallel 64-tap tap array with one shared I/Q MAC pair.
- Accepts one complex sample per valid/ready handshake and stores it in a circular sample buffer. Sequences the MAC over all taps, then presents one filtered complex output with backpressure.
- Holds two coefficient banks (active/shadow) so that new coefficients can be loaded at runtime and swapped only on a sample boundary.

---
 rtl/fir_tdm_sequencer.sv | 152 +++++++++++++++
 tb/tb_fir_tdm_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tdm_sequencer.sv
// fir_tdm_sequencer: time-multiplexed complex FIR, one shared I/Q MAC pair stepped over all taps,
// with active/shadow coefficient banks swapped only between samples.
module fir_tdm_sequencer #(
    parameter int NTAPS     = 64,
    parameter int DW        = 12,
    parameter int CW        = 16,
    parameter int OUT_SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DW-1:0]       in_data_i,
    input  logic signed [DW-1:0]       in_data_q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DW-1:0]       out_data_i,
    output logic signed [DW-1:0]       out_data_q,
    input  logic                       cfg_we,
    input  logic [$clog2(NTAPS)-1:0]   cfg_addr,
    input  logic signed [CW-1:0]       cfg_data,
    input  logic                       cfg_swap,
    output logic                       cfg_swap_pending,
    output logic                       busy
);
    localparam int IW = $clog2(NTAPS);
    localparam int PW = DW + CW;
    localparam int AW = PW + IW;
    localparam int SH = CW - 1 + OUT_SHIFT;
    localparam logic signed [AW-1:0] SAT_HI = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         k_q, k_d;
    logic [IW-1:0]         base_q, base_d;
    logic [IW-1:0]         wr_ptr_q, wr_ptr_d;
    logic                  bank_sel_q, bank_sel_d;
    logic                  swap_pending_q, swap_pending_d;
    logic signed [AW-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [DW-1:0]  out_re_q, out_re_d, out_im_q, out_im_d;
    logic signed [CW-1:0]  coef_q [2][NTAPS];
    logic signed [DW-1:0]  buf_re_q [NTAPS];
    logic signed [DW-1:0]  buf_im_q [NTAPS];

    logic                  accept;
    logic                  swap_apply;
    logic [IW-1:0]         rd_idx;
    logic signed [CW-1:0]  coef;
    logic signed [PW-1:0]  prod_re, prod_im;
    logic signed [AW-1:0]  acc_re_nx, acc_im_nx;

    function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> SH;
        return (s > SAT_HI) ? SAT_HI[DW-1:0] : (s < SAT_LO) ? SAT_LO[DW-1:0] : s[DW-1:0];
    endfunction

    assign in_ready         = (state_q == IDLE) && !rst;
    assign busy             = state_q != IDLE;
    assign out_valid        = state_q == OUT;
    assign out_data_i       = out_re_q;
    assign out_data_q       = out_im_q;
    assign cfg_swap_pending = swap_pending_q;
    assign accept           = in_valid && in_ready;
    assign swap_apply       = (state_q == IDLE) && swap_pending_q;

    // Newest sample sits at base; tap k reads k samples back, wrapping in the IW-bit index.
    assign rd_idx    = base_q - k_q;
    assign coef      = coef_q[bank_sel_q][k_q];
    assign prod_re   = PW'(coef) * PW'(buf_re_q[rd_idx]);
    assign prod_im   = PW'(coef) * PW'(buf_im_q[rd_idx]);
    assign acc_re_nx = acc_re_q + AW'(prod_re);
    assign acc_im_nx = acc_im_q + AW'(prod_im);

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        base_d         = base_q;
        wr_ptr_d       = wr_ptr_q;
        acc_re_d       = acc_re_q;
        acc_im_d       = acc_im_q;
        out_re_d       = out_re_q;
        out_im_d       = out_im_q;
        bank_sel_d     = swap_apply ? ~bank_sel_q : bank_sel_q;
        swap_pending_d = !swap_apply && (swap_pending_q || cfg_swap);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = RUN;
                    base_d   = wr_ptr_q;
                    k_d      = '0;
                    acc_re_d = '0;
                    acc_im_d = '0;
                end
            end
            RUN: begin
                acc_re_d = acc_re_nx;
                acc_im_d = acc_im_nx;
                k_d      = k_q + 1'b1;
                if (k_q == IW'(NTAPS - 1)) begin
                    state_d  = OUT;
                    out_re_d = sat(acc_re_nx);
                    out_im_d = sat(acc_im_nx);
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            OUT: state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            k_q            <= '0;
            base_q         <= '0;
            wr_ptr_q       <= '0;
            bank_sel_q     <= 1'b0;
            swap_pending_q <= 1'b0;
            acc_re_q       <= '0;
            acc_im_q       <= '0;
            out_re_q       <= '0;
            out_im_q       <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                buf_re_q[i]   <= '0;
                buf_im_q[i]   <= '0;
                coef_q[0][i]  <= '0;
                coef_q[1][i]  <= '0;
            end
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            base_q         <= base_d;
            wr_ptr_q       <= wr_ptr_d;
            bank_sel_q     <= bank_sel_d;
            swap_pending_q <= swap_pending_d;
            acc_re_q       <= acc_re_d;
            acc_im_q       <= acc_im_d;
            out_re_q       <= out_re_d;
            out_im_q       <= out_im_d;
            if (accept) begin
                buf_re_q[wr_ptr_q] <= in_data_i;
                buf_im_q[wr_ptr_q] <= in_data_q;
            end
            // Shadow is chosen from the pre-edge bank_sel, even when a swap lands this edge.
            if (cfg_we)
                coef_q[~bank_sel_q][cfg_addr] <= cfg_data;
        end
    end
endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// tb_fir_tdm_sequencer: scoreboard bench; an arithmetic FIR model predicts each output and its arrival cycle.
module tb_fir_tdm_sequencer;
    localparam int NTAPS = 64;
    localparam int DW    = 12;
    localparam int CW    = 16;
    localparam int SH    = 17;
    localparam int MAXV  = 2047;
    localparam int MINV  = -2048;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  out_ready = 1'b0;
    logic                  cfg_we = 1'b0;
    logic                  cfg_swap = 1'b0;
    logic [5:0]            cfg_addr = '0;
    logic signed [CW-1:0]  cfg_data = '0;
    logic signed [DW-1:0]  in_data_i = '0;
    logic signed [DW-1:0]  in_data_q = '0;
    logic                  in_ready, out_valid, cfg_swap_pending, busy;
    logic signed [DW-1:0]  out_data_i, out_data_q;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    typedef struct {longint re; longint im; longint rise;} exp_t;
    exp_t sb[$];
    int   tx_i[$];
    int   tx_q[$];

    int   m_coef [2][NTAPS];
    int   m_hi [NTAPS];
    int   m_hq [NTAPS];
    int   m_wr, m_bank, m_phase, m_run;
    bit   m_pend;

    fir_tdm_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data_i(in_data_i), .in_data_q(in_data_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_i(out_data_i), .out_data_q(out_data_q),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_swap(cfg_swap), .cfg_swap_pending(cfg_swap_pending), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NTAPS; i++) begin
            m_coef[0][i] = 0;
            m_coef[1][i] = 0;
            m_hi[i] = 0;
            m_hq[i] = 0;
        end
        m_wr = 0; m_bank = 0; m_phase = 0; m_run = 0; m_pend = 0;
        sb.delete();
    endtask

    // Convolution of the newest NTAPS samples with the active bank, scaled by 2^-17 (floor) and clamped.
    function automatic longint fir(input bit im);
        longint acc = 0;
        for (int k = 0; k < NTAPS; k++) begin
            int idx = (m_wr - k + NTAPS) % NTAPS;
            acc += longint'(m_coef[m_bank][k]) * longint'(im ? m_hq[idx] : m_hi[idx]);
        end
        acc = acc >>> SH;
        return acc > MAXV ? MAXV : acc < MINV ? MINV : acc;
    endfunction

    task automatic cycle();
        bit idle = (m_phase == 0);
        if (rst) begin
            chk("in_ready_in_reset", in_ready, 0);
            model_reset();
        end else begin
            chk("in_ready", in_ready, idle);
            chk("busy", busy, !idle);
            chk("swap_pending", cfg_swap_pending, m_pend);
            if (cfg_we) m_coef[m_bank ^ 1][cfg_addr] = cfg_data;
            if (idle && m_pend) begin
                m_bank ^= 1;
                m_pend = 0;
            end else if (cfg_swap) m_pend = 1;
            if (in_valid && idle) begin
                m_hi[m_wr] = in_data_i;
                m_hq[m_wr] = in_data_q;
                sb.push_back('{fir(0), fir(1), cyc + 1 + NTAPS});
                m_wr = (m_wr + 1) % NTAPS;
                m_phase = 1;
                m_run = NTAPS;
            end else if (m_phase == 1) begin
                m_run--;
                if (m_run == 0) m_phase = 2;
            end else if (m_phase == 2 && out_ready) m_phase = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int p_valid, input int p_ready, input int p_cfg);
        int guard = 0;
        while ((tx_i.size() > 0 || m_phase != 0 || sb.size() > 0) && guard < 20000) begin
            in_valid = tx_i.size() > 0 && ($urandom_range(99) < p_valid);
            if (in_valid && m_phase == 0) begin
                in_data_i = DW'(tx_i.pop_front());
                in_data_q = DW'(tx_q.pop_front());
            end else begin
                in_data_i = DW'($urandom);
                in_data_q = DW'($urandom);
            end
            out_ready = $urandom_range(99) < p_ready;
            cfg_we    = $urandom_range(99) < p_cfg;
            cfg_addr  = 6'($urandom_range(NTAPS - 1));
            cfg_data  = CW'($urandom);
            cfg_swap  = $urandom_range(399) < p_cfg;
            cycle();
            guard++;
        end
        in_valid = 0; cfg_we = 0; cfg_swap = 0; out_ready = 1;
        chk("drain", tx_i.size() + m_phase + sb.size(), 0);
    endtask

    task automatic load_shadow(input int v);
        out_ready = 1;
        for (int a = 0; a < NTAPS; a++) begin
            cfg_we = 1;
            cfg_addr = 6'(a);
            cfg_data = CW'(v);
            cycle();
        end
        cfg_we = 0;
        cfg_swap = 1;
        cycle();
        cfg_swap = 0;
        cycle();
    endtask

    task automatic push(input int i, input int q);
        tx_i.push_back(i);
        tx_q.push_back(q);
    endtask

    initial begin : monitor
        bit pv = 0;
        forever begin
            @(negedge clk);
            if (rst) pv = 0;
            else begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got %0d/%0d expected no output", out_data_i, out_data_q);
                    end else begin
                        if (!pv) chk("latency", cyc, sb[0].rise);
                        chk("out_i", out_data_i, sb[0].re);
                        chk("out_q", out_data_q, sb[0].im);
                        if (out_ready) void'(sb.pop_front());
                    end
                end
                pv = out_valid;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_i", out_data_i, 0);
        chk("rst_out_q", out_data_q, 0);
        chk("rst_pending", cfg_swap_pending, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        #1;
        for (int n = 0; n < 3; n++) push(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
        run(100, 100, 0);
        load_shadow(16384);
        push(2047, -2047);
        for (int n = 0; n < 65; n++) push(0, 0);
        run(100, 100, 0);
        load_shadow(32767);
        for (int n = 0; n < 64; n++) push(2047, -2048);
        run(100, 100, 0);
        for (int n = 0; n < 6; n++) push(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
        run(80, 5, 0);
        for (int n = 0; n < 20; n++) push(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
        run(70, 60, 15);
        load_shadow(16384);
        in_valid = 1; in_data_i = 12'sd2047; in_data_q = -12'sd2047;
        cycle();
        in_valid = 0;
        repeat (30) cycle();
        rst = 1;
        cycle();
        chk("midrun_out_valid", out_valid, 0);
        chk("midrun_busy", busy, 0);
        rst = 0;
        #1;
        chk("midrun_in_ready", in_ready, 1);
        push(2047, -2047);
        push(0, 0);
        run(100, 100, 0);
        load_shadow(16384);
        push(2047, -2047);
        for (int n = 0; n < 3; n++) push(0, 0);
        run(100, 100, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
